// File: rtl/ysyx_22050710_if_stage.sv
// ---------------------------------------------------------------------------
// ysyx_22050710_if_stage
//
// Instruction fetch stage. It keeps a fetch PC and issues one request at a
// time to instruction memory. It captures the response into a single output
// register that the decode stage drains with i_idu_allowin. A redirect from
// the branch/system unit overrides everything else. A request that is already
// in flight when a redirect arrives is marked cancelled, and its response is
// dropped when it comes back.
//
// Optional feature (macro YSYX_22050710_IF_MISALIGN_CHECK_EN):
//   When the macro is defined, a fetch PC whose low two bits are not zero is
//   never sent to memory. The stage instead emits a fault entry carrying
//   {fetch PC, nop, o_excp=1} and parks in HALT until a redirect or reset.
//   When the macro is undefined, the PC is issued unchecked and o_excp is 0.
//
// Parameters:
//   RESET_PC            first fetch address after reset
//
// Ports:
//   i_clk               clock, all state changes on the rising edge
//   i_rst               synchronous active-high reset
//   i_br_valid          redirect request
//   i_br_target         redirect target PC
//   o_imem_req          fetch request to instruction memory
//   o_imem_addr         fetch address
//   i_imem_gnt          request accepted this cycle
//   i_imem_rvalid       response valid (at least one cycle after grant)
//   i_imem_rdata        fetched instruction
//   i_idu_allowin       decode accepts the output register this cycle
//   o_ifu_to_idu_valid  output register holds a valid entry
//   o_pc                PC of the output entry
//   o_inst              instruction of the output entry
//   o_excp              output entry is an instruction-address-misaligned fault
// ---------------------------------------------------------------------------
module ysyx_22050710_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_br_valid,
  input  logic [63:0] i_br_target,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_idu_allowin,
  output logic        o_ifu_to_idu_valid,
  output logic [63:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_excp
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic        cancel;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;

  logic        out_free;
  logic        misaligned;

  // The output register can take a new entry when it is empty, or when decode
  // drains it this same cycle.
  assign out_free = !out_valid || i_idu_allowin;

`ifdef YSYX_22050710_IF_MISALIGN_CHECK_EN
  assign misaligned = (fetch_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Requests are only raised from REQ. This keeps at most one request
  // outstanding and limits throughput to two cycles per instruction.
  always_comb begin
    o_imem_req  = (state == ST_REQ) && out_free && !misaligned;
    o_imem_addr = fetch_pc;
  end

  assign o_ifu_to_idu_valid = out_valid;
  assign o_pc               = out_pc;
  assign o_inst             = out_inst;
  assign o_excp             = out_excp;

  // Single state machine that owns the fetch PC, cancel flag and output
  // register. Reset comes first, then redirect. Normal fetch and drain
  // only run when neither is active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= 64'h0;
      cancel    <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= 64'h0;
      out_inst  <= 32'h0;
      out_excp  <= 1'b0;
    end else if (i_br_valid) begin
      fetch_pc  <= i_br_target;
      out_valid <= 1'b0;
      out_excp  <= 1'b0;
      unique case (state)
        ST_REQ: begin
          // A grant on the redirect cycle still launches a request, so we must
          // wait for its response and throw it away.
          if (o_imem_req && i_imem_gnt) begin
            req_pc <= fetch_pc;
            cancel <= 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) begin
            cancel <= 1'b0;
            state  <= ST_REQ;
          end else begin
            cancel <= 1'b1;
          end
        end
        default: state <= ST_REQ;
      endcase
    end else begin
      if (out_valid && i_idu_allowin) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        ST_REQ: begin
          if (misaligned && out_free) begin
            out_valid <= 1'b1;
            out_pc    <= fetch_pc;
            out_inst  <= NOP_INST;
            out_excp  <= 1'b1;
            state     <= ST_HALT;
          end else if (o_imem_req && i_imem_gnt) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_imem_rvalid) begin
            if (cancel) begin
              cancel <= 1'b0;
            end else begin
              out_valid <= 1'b1;
              out_pc    <= req_pc;
              out_inst  <= i_imem_rdata;
              out_excp  <= 1'b0;
            end
            state <= ST_REQ;
          end
        end
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
